// File: rtl/shot_link.sv
// rtl/shot_link.sv - shot-exchange protocol engine over a UART byte link.
// Define SHOT_LINK_RETRY_EN to retransmit unanswered SHOT frames before flagging a link error.
module shot_link #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       shot_req,
  input  logic [7:0] shot_addr,
  output logic [1:0] msg_send,
  output logic [1:0] msg_in,
  output logic [7:0] check_in,
  output logic [7:0] board_addr,
  input  logic       board_hit,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       link_err
);

  localparam logic [7:0] BYTE_HDR  = 8'hA0;
  localparam logic [7:0] BYTE_MISS = 8'hB1;
  localparam logic [7:0] BYTE_HIT  = 8'hB2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

`ifdef SHOT_LINK_RETRY_EN
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
`else
  localparam logic [RW-1:0] RETRY_LIMIT = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_TX_HDR, S_TX_ADDR, S_WAIT_RES, S_RX_ADDR, S_LOOKUP, S_TX_RES, S_ERR
  } state_t;

  state_t          state, state_n;
  logic            shot_req_q;
  logic            req_pend;
  logic [7:0]      pend_addr;
  logic [7:0]      shot_reg;
  logic [TW-1:0]   tmo_cnt;
  logic [RW-1:0]   retry_cnt;
  logic            tx_start_q;
  logic            send_seen;
  logic            in_seen;

  logic            tx_ok;
  logic            rx_res;
  logic            tmo_done;
  logic            do_tx;
  logic [7:0]      tx_byte;
  logic            take_req;
  logic            cap_addr;
  logic            load_send;
  logic            load_in;
  logic            retry_inc;
  logic            retry_clr;

  // Busy is not trusted in the strobe cycle or the one after it, so hold off both.
  assign tx_ok    = !tx_busy && !tx_start && !tx_start_q;
  assign rx_res   = rx_valid && (rx_data == BYTE_MISS || rx_data == BYTE_HIT);
  assign tmo_done = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_tx     = 1'b0;
    tx_byte   = BYTE_HDR;
    take_req  = 1'b0;
    cap_addr  = 1'b0;
    load_send = 1'b0;
    load_in   = 1'b0;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == BYTE_HDR) begin
          state_n = S_RX_ADDR;
        end else if (req_pend) begin
          take_req = 1'b1;
          state_n  = S_TX_HDR;
        end
      end
      S_TX_HDR: begin
        if (tx_ok) begin
          do_tx   = 1'b1;
          tx_byte = BYTE_HDR;
          state_n = S_TX_ADDR;
        end
      end
      S_TX_ADDR: begin
        if (tx_ok) begin
          do_tx   = 1'b1;
          tx_byte = shot_reg;
          state_n = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (rx_res) begin
          load_send = 1'b1;
          retry_clr = 1'b1;
          state_n   = S_IDLE;
        end else if (tmo_done) begin
          if (retry_cnt == RETRY_LIMIT) begin
            state_n = S_ERR;
          end else begin
            retry_inc = 1'b1;
            state_n   = S_TX_HDR;
          end
        end
      end
      S_RX_ADDR: begin
        if (rx_valid) begin
          cap_addr = 1'b1;
          state_n  = S_LOOKUP;
        end else if (tmo_done) begin
          state_n = S_IDLE;
        end
      end
      S_LOOKUP: state_n = S_TX_RES;
      S_TX_RES: begin
        if (tx_ok) begin
          do_tx   = 1'b1;
          tx_byte = board_hit ? BYTE_HIT : BYTE_MISS;
          load_in = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_ERR:   state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shot_req_q <= 1'b0;
      req_pend   <= 1'b0;
      pend_addr  <= '0;
      shot_reg   <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      tx_start   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data    <= '0;
      check_in   <= '0;
      board_addr <= '0;
      msg_send   <= '0;
      msg_in     <= '0;
      send_seen  <= 1'b0;
      in_seen    <= 1'b0;
      link_err   <= 1'b0;
    end else begin
      shot_req_q <= shot_req;
      if (shot_req && !shot_req_q) begin
        req_pend  <= 1'b1;
        pend_addr <= shot_addr;
      end else if (take_req) begin
        req_pend <= 1'b0;
      end
      if (take_req) shot_reg <= pend_addr;

      // Counter runs only while parked in a waiting state; any transition zeroes it.
      if ((state == S_WAIT_RES || state == S_RX_ADDR) && state_n == state)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;

      if (retry_clr)      retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + RW'(1);

      tx_start   <= do_tx;
      tx_start_q <= tx_start;
      if (do_tx) tx_data <= tx_byte;

      if (cap_addr) begin
        check_in   <= rx_data;
        board_addr <= rx_data;
      end

      // Results survive until the second frame boundary after their load.
      if (load_send) begin
        msg_send  <= (rx_data == BYTE_HIT) ? 2'b10 : 2'b01;
        send_seen <= 1'b0;
      end else if (frame_start && msg_send != 2'b00) begin
        if (send_seen) begin
          msg_send  <= 2'b00;
          send_seen <= 1'b0;
        end else begin
          send_seen <= 1'b1;
        end
      end

      if (load_in) begin
        msg_in  <= {board_hit, !board_hit};
        in_seen <= 1'b0;
      end else if (frame_start && msg_in != 2'b00) begin
        if (in_seen) begin
          msg_in  <= 2'b00;
          in_seen <= 1'b0;
        end else begin
          in_seen <= 1'b1;
        end
      end

      if (state_n == S_ERR) link_err <= 1'b1;
    end
  end

endmodule
